// File: rtl/evt_stream_rr_arbiter.sv
// Round-robin merge of NUM_INPUTS valid/ready event streams into one registered output entry.
// Define EVT_STREAM_RR_ARBITER_STATS_EN to build the saturating dst_count_o transfer counter.
module evt_stream_rr_arbiter #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic [NUM_INPUTS-1:0]            src_valid_i,
  output logic [NUM_INPUTS-1:0]            src_ready_o,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] src_data_i,
  output logic                             dst_valid_o,
  input  logic                             dst_ready_i,
  output logic [DATA_WIDTH-1:0]            dst_data_o,
  output logic [IDX_W-1:0]                 dst_idx_o,
  output logic [31:0]                      dst_count_o
);

  // state | meaning
  // EMPTY | no entry held, dst_valid_o low
  // FULL  | entry held in data_q/idx_q, dst_valid_o high until accepted
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        ptr_q;

  logic                    load_en;
  logic                    grant_found;
  logic                    grant_vld;
  int                      grant_sel;
  int                      cand;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        ptr_nxt;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Reset gates load_en so no input sees an accept while rst_ni is low.
  assign load_en = rst_ni & enable_i & ((state_q == EMPTY) | dst_ready_i);

  always_comb begin
    grant_found = 1'b0;
    grant_sel   = 0;
    cand        = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      if (!grant_found && src_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
      end
    end
  end

  assign grant_vld  = load_en & grant_found;
  assign grant_idx  = grant_sel[IDX_W-1:0];
  assign grant_data = src_data_i[grant_sel*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_nxt    = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    src_ready_o = '0;
    if (grant_vld) src_ready_o[grant_sel] = 1'b1;
  end

  // A grant while FULL and dst_ready_i high replaces the entry in the same cycle it drains.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (grant_vld) begin
      state_q <= FULL;
      data_q  <= grant_data;
      idx_q   <= grant_idx;
      ptr_q   <= ptr_nxt;
    end else if ((state_q == FULL) && dst_ready_i) begin
      state_q <= EMPTY;
    end
  end

  assign dst_valid_o = (state_q == FULL);
  assign dst_data_o  = data_q;
  assign dst_idx_o   = idx_q;

`ifdef EVT_STREAM_RR_ARBITER_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (dst_valid_o && dst_ready_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign dst_count_o = count_q;
`else
  assign dst_count_o = '0;
`endif

endmodule

// File: tb/tb_evt_stream_rr_arbiter.sv
// Directed bench for evt_stream_rr_arbiter with four inputs: fairness, backpressure, wrap,
// enable, mid-operation reset and the optional transfer counter.
module tb_evt_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_ni;
  logic            enable_i;
  logic [N-1:0]    src_valid_i;
  logic [N-1:0]    src_ready_o;
  logic [N*DW-1:0] src_data_i;
  logic            dst_valid_o;
  logic            dst_ready_i;
  logic [DW-1:0]   dst_data_o;
  logic [1:0]      dst_idx_o;
  logic [31:0]     dst_count_o;

  int checks = 0;
  int errors = 0;

  evt_stream_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_data_i  (src_data_i),
    .dst_valid_o (dst_valid_o),
    .dst_ready_i (dst_ready_i),
    .dst_data_o  (dst_data_o),
    .dst_idx_o   (dst_idx_o),
    .dst_count_o (dst_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] word_of(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  task automatic set_default_data();
    for (int i = 0; i < N; i++) src_data_i[i*DW +: DW] = word_of(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    enable_i    = 1'b1;
    dst_ready_i = 1'b1;
    src_valid_i = 4'b1111;
    #1;
    checks++;
    if (src_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", src_ready_o);
    end
    tick();
    tick();
    checks++;
    if (dst_valid_o !== 1'b0 || dst_data_o !== 32'h0 || dst_idx_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h idx=%0d want 0/0/0", dst_valid_o, dst_data_o, dst_idx_o);
    end
    checks++;
    if (dst_count_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", dst_count_o);
    end
    src_valid_i = '0;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    src_valid_i = 4'b1111;
    dst_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (src_ready_o !== 4'(1 << exp_g[c])) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got %b want %b", c, src_ready_o, 4'(1 << exp_g[c]));
      end
      tick();
      checks++;
      if (dst_valid_o !== 1'b1 || dst_idx_o !== 2'(exp_g[c]) || dst_data_o !== word_of(exp_g[c])) begin
        errors++;
        $display("FAIL fair_out[%0d]: got valid=%b idx=%0d data=%h want 1/%0d/%h",
                 c, dst_valid_o, dst_idx_o, dst_data_o, exp_g[c], word_of(exp_g[c]));
      end
    end
    src_valid_i = '0;
    tick();
    checks++;
    if (dst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fair_drain: got valid=%b want 0", dst_valid_o);
    end
  endtask

  task automatic test_backpressure();
    src_data_i[2*DW +: DW] = 32'hA5A5_A5A5;
    src_valid_i = 4'b0100;
    dst_ready_i = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0100", src_ready_o);
    end
    tick();
    dst_ready_i = 1'b0;
    src_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (src_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", c, src_ready_o);
      end
      tick();
      checks++;
      if (dst_valid_o !== 1'b1 || dst_data_o !== 32'hA5A5_A5A5 || dst_idx_o !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h idx=%0d want 1/a5a5a5a5/2",
                 c, dst_valid_o, dst_data_o, dst_idx_o);
      end
    end
    src_valid_i = '0;
    dst_ready_i = 1'b1;
    tick();
    checks++;
    if (dst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b want 0", dst_valid_o);
    end
    set_default_data();
  endtask

  // Pointer sits at 3 after the grant to input 2 in the backpressure test.
  task automatic test_wrap();
    src_valid_i = 4'b0011;
    dst_ready_i = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant0: got %b want 0001", src_ready_o);
    end
    tick();
    checks++;
    if (dst_idx_o !== 2'd0 || dst_data_o !== word_of(0)) begin
      errors++;
      $display("FAIL wrap_out0: got idx=%0d data=%h want 0/%h", dst_idx_o, dst_data_o, word_of(0));
    end
    checks++;
    if (src_ready_o !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant1: got %b want 0010", src_ready_o);
    end
    tick();
    checks++;
    if (dst_idx_o !== 2'd1 || dst_data_o !== word_of(1)) begin
      errors++;
      $display("FAIL wrap_out1: got idx=%0d data=%h want 1/%h", dst_idx_o, dst_data_o, word_of(1));
    end
    src_valid_i = '0;
    tick();
  endtask

  task automatic test_enable();
    src_valid_i = 4'b1000;
    dst_ready_i = 1'b1;
    tick();
    checks++;
    if (dst_valid_o !== 1'b1 || dst_idx_o !== 2'd3) begin
      errors++;
      $display("FAIL en_fill: got valid=%b idx=%0d want 1/3", dst_valid_o, dst_idx_o);
    end
    enable_i    = 1'b0;
    src_valid_i = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (src_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL en_ready[%0d]: got %b want 0000", c, src_ready_o);
      end
      tick();
      checks++;
      if (dst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL en_drain[%0d]: got valid=%b want 0", c, dst_valid_o);
      end
    end
    enable_i    = 1'b1;
    src_valid_i = '0;
  endtask

  // Pointer is 0 here; a grant to 2 moves it to 3 before the reset.
  task automatic test_reset_mid();
    src_valid_i = 4'b0100;
    dst_ready_i = 1'b1;
    tick();
    dst_ready_i = 1'b0;
    src_valid_i = 4'b1100;
    rst_ni      = 1'b0;
    #1;
    checks++;
    if (src_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b want 0000", src_ready_o);
    end
    tick();
    checks++;
    if (dst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %b want 0", dst_valid_o);
    end
    rst_ni      = 1'b1;
    dst_ready_i = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_grant: got %b want 0100", src_ready_o);
    end
    tick();
    checks++;
    if (dst_valid_o !== 1'b1 || dst_idx_o !== 2'd2) begin
      errors++;
      $display("FAIL rst_mid_out: got valid=%b idx=%0d want 1/2", dst_valid_o, dst_idx_o);
    end
    src_valid_i = '0;
    tick();
  endtask

  task automatic test_stats();
    logic [31:0] exp_cnt;
    do_reset();
    src_valid_i = 4'b1111;
    dst_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    src_valid_i = '0;
    tick();
`ifdef EVT_STREAM_RR_ARBITER_STATS_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (dst_count_o !== exp_cnt) begin
      errors++;
      $display("FAIL stats_count: got %0d want %0d", dst_count_o, exp_cnt);
    end
    checks++;
    if (dst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stats_drain: got valid=%b want 0", dst_valid_o);
    end
    do_reset();
    #1;
    checks++;
    if (dst_count_o !== 32'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d want 0", dst_count_o);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b1;
    dst_ready_i = 1'b0;
    src_valid_i = '0;
    src_data_i  = '0;
    set_default_data();
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evt_stream_rr_arbiter.md
EVT_STREAM_RR_ARBITER -- requirements
Module: evt_stream_rr_arbiter

Interface
REQ-001 SHALL provide parameter NUM_INPUTS, default 8, number of merged event streams (legal range 1..32).
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, event word width in bits.
REQ-003 SHALL provide port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL provide port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port enable_i  input  1  arbitration enable; low blocks new grants.
REQ-006 SHALL provide port src_valid_i  input  NUM_INPUTS  per-input event valid.
REQ-007 SHALL provide port src_ready_o  output  NUM_INPUTS  per-input accept; at most one bit high.
REQ-008 SHALL provide port src_data_i  input  NUM_INPUTS*DATA_WIDTH  per-input event words; input i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL provide port dst_valid_o  output  1  merged stream valid, towards the stream selector.
REQ-010 SHALL provide port dst_ready_i  input  1  merged stream ready.
REQ-011 SHALL provide port dst_data_o  output  DATA_WIDTH  merged event word.
REQ-012 SHALL provide port dst_idx_o  output  max(1,$clog2(NUM_INPUTS))  index of the input that produced dst_data_o.
REQ-013 SHALL provide port dst_count_o  output  32  accepted-output event counter.

Function
REQ-014 SHALL hold one registered output entry; states EMPTY (dst_valid_o=0) and FULL (dst_valid_o=1).
REQ-015 SHALL define load_en = enable_i AND (EMPTY OR dst_ready_i).
REQ-016 SHALL, when load_en and any src_valid_i high, grant the first valid index searching upward from pointer ptr with wrap past NUM_INPUTS-1 to 0.
REQ-017 SHALL assert src_ready_o[g] combinationally for granted g only; all other bits 0; all bits 0 when load_en low.
REQ-018 SHALL, on grant, register src_data_i slice g into dst_data_o and g into dst_idx_o, entering/remaining FULL; latency input-accept to dst_valid_o = 1 cycle.
REQ-019 SHALL, on grant, set ptr = g+1, wrapping NUM_INPUTS-1 to 0; ptr unchanged without grant.
REQ-020 SHALL, in FULL with dst_ready_i high and no grant, go EMPTY next cycle.
REQ-021 SHALL sustain one event per cycle when dst_ready_i stays high and any input is valid (simultaneous drain and load).
REQ-022 SHALL keep dst_data_o, dst_idx_o, dst_valid_o stable while dst_valid_o=1 and dst_ready_i=0.
REQ-023 SHALL, with enable_i low, still present and drain a FULL entry; no new load.
REQ-024 SHALL not depend on src_valid_i being stable; a deasserted request is simply not granted.
REQ-025 SHALL, for NUM_INPUTS=1, behave as a single-entry pipeline register with dst_idx_o=0.

Reset
REQ-026 SHALL, when rst_ni low at a clock edge, set EMPTY, dst_valid_o=0, dst_data_o=0, dst_idx_o=0, ptr=0, dst_count_o=0.
REQ-027 SHALL, on reset mid-operation, discard a held FULL entry without handshake; src_ready_o=0 during reset cycles.

Configuration
REQ-028 SHALL compile the event counter only when macro EVT_STREAM_RR_ARBITER_STATS_EN is defined.
REQ-029 SHALL, with the macro, increment dst_count_o on each cycle with dst_valid_o AND dst_ready_i, saturating at 0xFFFFFFFF.
REQ-030 SHALL, without the macro, keep port dst_count_o present and tied to 0, with no counter flops.

Verification
REQ-031 SHALL cover fairness: NUM_INPUTS=4, all valid, dst_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, dst_idx_o follows one cycle later.
REQ-032 SHALL cover backpressure: FULL with data 0xA5A5A5A5, dst_ready_i=0 for 5 cycles -> outputs stable, src_ready_o=0, then one transfer on ready.
REQ-033 SHALL cover wrap: ptr=3 (after grant to 2), only inputs 0 and 1 valid -> grant 0, then 1.
REQ-034 SHALL cover enable: enable_i=0 while FULL and dst_ready_i=1 -> entry drains, dst_valid_o=0 next cycle, no grants.
REQ-035 SHALL cover reset mid-operation: rst_ni low 1 cycle while FULL -> dst_valid_o=0, ptr=0, next grant to lowest valid index.
REQ-036 SHALL cover stats: macro defined, 10 transfers -> dst_count_o=10; macro undefined -> dst_count_o=0.
